// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: opcodes, functional-unit codes, operand selects and op encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package decode_queue_pkg;

  localparam int ALU_OP_WIDTH = 4;
  localparam int LSQ_OP_WIDTH = 4;
  localparam int BRA_OP_WIDTH = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Code 0 in every field means "nothing"; an illegal entry is all zero apart from its flag.
  typedef enum logic [2:0] {FU_NONE = 3'd0, FU_ALU = 3'd1, FU_LSQ = 3'd2, FU_BRA = 3'd3} fu_e;

  typedef enum logic [3:0] {
    IMM_NONE = 4'd0, IMM_I = 4'd1, IMM_S = 4'd2, IMM_B = 4'd3, IMM_U = 4'd4, IMM_J = 4'd5
  } imm_sel_e;

  typedef enum logic [1:0] {OPA_NONE = 2'd0, OPA_RS1 = 2'd1, OPA_PC = 2'd2} opa_sel_e;
  typedef enum logic [1:0] {OPB_NONE = 2'd0, OPB_IMM = 2'd1, OPB_RS2 = 2'd2} opb_sel_e;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLL = 4'd3, ALU_SLT = 4'd4,
    ALU_SLTU = 4'd5, ALU_XOR = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8, ALU_OR = 4'd9,
    ALU_AND = 4'd10, ALU_OUTB = 4'd11
  } alu_op_e;

  typedef enum logic [LSQ_OP_WIDTH-1:0] {
    LSQ_NONE = 4'd0, LSQ_LB = 4'd1, LSQ_LH = 4'd2, LSQ_LW = 4'd3, LSQ_LBU = 4'd4,
    LSQ_LHU = 4'd5, LSQ_SB = 4'd6, LSQ_SH = 4'd7, LSQ_SW = 4'd8
  } lsq_op_e;

  typedef enum logic [BRA_OP_WIDTH-1:0] {
    BRA_NONE = 4'd0, BRA_BEQ = 4'd1, BRA_BNE = 4'd2, BRA_BLT = 4'd3, BRA_BGE = 4'd4,
    BRA_BLTU = 4'd5, BRA_BGEU = 4'd6, BRA_JAL = 4'd7, BRA_JALR = 4'd8
  } bra_op_e;

  typedef struct packed {
    fu_e      fu;
    logic     reg_write;
    logic     illegal;
    imm_sel_e imm_sel;
    opa_sel_e opa_sel;
    opb_sel_e opb_sel;
    alu_op_e  alu;
    lsq_op_e  mem;
    bra_op_e  bra;
  } dec_t;

endpackage

// File: rtl/decode_queue_if.sv
// Enqueue/dequeue bundle of the decode queue; slave = the queue, master = fetch/dispatch side.
// Latency: wires only.
// Backpressure: enq_ready gates enqueue; deq_count tells the queue how many offered slots were taken.
interface decode_queue_if #(
  parameter int WIDTH = 2
) ();
  logic [WIDTH-1:0]                                enq_valid;
  logic [WIDTH*32-1:0]                             enq_inst;
  logic [WIDTH*32-1:0]                             enq_pc;
  logic                                            enq_ready;
  logic [WIDTH-1:0]                                deq_valid;
  logic [WIDTH*32-1:0]                             deq_pc;
  logic [WIDTH*3-1:0]                              deq_fu_type;
  logic [WIDTH-1:0]                                deq_reg_write;
  logic [WIDTH-1:0]                                deq_illegal;
  logic [WIDTH*4-1:0]                              deq_imm_sel;
  logic [WIDTH*2-1:0]                              deq_opa_sel;
  logic [WIDTH*2-1:0]                              deq_opb_sel;
  logic [WIDTH*decode_queue_pkg::ALU_OP_WIDTH-1:0] deq_alu_ctrl;
  logic [WIDTH*decode_queue_pkg::LSQ_OP_WIDTH-1:0] deq_mem_ctrl;
  logic [WIDTH*decode_queue_pkg::BRA_OP_WIDTH-1:0] deq_bra_ctrl;
  logic [$clog2(WIDTH+1)-1:0]                      deq_count;

  modport slave (
    input  enq_valid, enq_inst, enq_pc, deq_count,
    output enq_ready, deq_valid, deq_pc, deq_fu_type, deq_reg_write, deq_illegal,
           deq_imm_sel, deq_opa_sel, deq_opb_sel, deq_alu_ctrl, deq_mem_ctrl, deq_bra_ctrl
  );

  modport master (
    output enq_valid, enq_inst, enq_pc, deq_count,
    input  enq_ready, deq_valid, deq_pc, deq_fu_type, deq_reg_write, deq_illegal,
           deq_imm_sel, deq_opa_sel, deq_opb_sel, deq_alu_ctrl, deq_mem_ctrl, deq_bra_ctrl
  );
endinterface

// File: rtl/decode_queue_decode_slot.sv
// RV32I single-instruction decoder producing the dispatch control word.
// Latency: purely combinational.
// Backpressure: none; output is valid whenever the input word is.
module decode_slot
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7_base;
  logic       f7_alt;
  logic       is_reg;
  logic       legal;
  logic       unused_fields;

  assign opcode  = inst_i[6:0];
  assign f3      = inst_i[14:12];
  assign f7_base = (inst_i[31:25] == F7_BASE);
  assign f7_alt  = (inst_i[31:25] == F7_ALT);
  assign is_reg  = opcode[5];  // OP vs OP-IMM differ only in bit 5
  // Register specifiers and most immediate bits are read by later stages, not here
  assign unused_fields = ^{inst_i[24:15], inst_i[11:7]};

  // Classify the encoding; anything unrecognised collapses to an all-zero word with illegal set
  always_comb begin
    dec_o = '0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec_o.fu = FU_ALU;  dec_o.reg_write = 1'b1; dec_o.imm_sel = IMM_U;
        dec_o.opb_sel = OPB_IMM; dec_o.alu = ALU_OUTB;
      end
      OPC_AUIPC: begin
        dec_o.fu = FU_ALU;  dec_o.reg_write = 1'b1; dec_o.imm_sel = IMM_U;
        dec_o.opa_sel = OPA_PC; dec_o.opb_sel = OPB_IMM; dec_o.alu = ALU_ADD;
      end
      OPC_JAL: begin
        dec_o.fu = FU_BRA;  dec_o.reg_write = 1'b1; dec_o.imm_sel = IMM_J;
        dec_o.opa_sel = OPA_PC; dec_o.opb_sel = OPB_IMM; dec_o.bra = BRA_JAL;
      end
      OPC_JALR: begin
        dec_o.fu = FU_BRA;  dec_o.reg_write = 1'b1; dec_o.imm_sel = IMM_I;
        dec_o.opa_sel = OPA_RS1; dec_o.opb_sel = OPB_IMM; dec_o.bra = BRA_JALR;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec_o.fu = FU_BRA;  dec_o.imm_sel = IMM_B;
        dec_o.opa_sel = OPA_RS1; dec_o.opb_sel = OPB_RS2;
        case (f3)
          3'b000:  dec_o.bra = BRA_BEQ;
          3'b001:  dec_o.bra = BRA_BNE;
          3'b100:  dec_o.bra = BRA_BLT;
          3'b101:  dec_o.bra = BRA_BGE;
          3'b110:  dec_o.bra = BRA_BLTU;
          3'b111:  dec_o.bra = BRA_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_o.fu = FU_LSQ;  dec_o.reg_write = 1'b1; dec_o.imm_sel = IMM_I;
        dec_o.opa_sel = OPA_RS1; dec_o.opb_sel = OPB_IMM; dec_o.alu = ALU_ADD;
        case (f3)
          3'b000:  dec_o.mem = LSQ_LB;
          3'b001:  dec_o.mem = LSQ_LH;
          3'b010:  dec_o.mem = LSQ_LW;
          3'b100:  dec_o.mem = LSQ_LBU;
          3'b101:  dec_o.mem = LSQ_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec_o.fu = FU_LSQ;  dec_o.imm_sel = IMM_S;
        dec_o.opa_sel = OPA_RS1; dec_o.opb_sel = OPB_IMM; dec_o.alu = ALU_ADD;
        case (f3)
          3'b000:  dec_o.mem = LSQ_SB;
          3'b001:  dec_o.mem = LSQ_SH;
          3'b010:  dec_o.mem = LSQ_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        dec_o.fu = FU_ALU;  dec_o.reg_write = 1'b1; dec_o.opa_sel = OPA_RS1;
        dec_o.opb_sel = is_reg ? OPB_RS2 : OPB_IMM;
        dec_o.imm_sel = is_reg ? IMM_NONE : IMM_I;
        case (f3)
          3'b000: dec_o.alu = (is_reg && f7_alt) ? ALU_SUB : ALU_ADD;
          3'b001: dec_o.alu = ALU_SLL;
          3'b010: dec_o.alu = ALU_SLT;
          3'b011: dec_o.alu = ALU_SLTU;
          3'b100: dec_o.alu = ALU_XOR;
          3'b101: dec_o.alu = f7_alt ? ALU_SRA : ALU_SRL;
          3'b110: dec_o.alu = ALU_OR;
          3'b111: dec_o.alu = ALU_AND;
        endcase
        // funct7 must be zero except SUB/SRA/SRAI; OP-IMM only constrains it for shifts
        if (is_reg || f3 == 3'b001 || f3 == 3'b101)
          legal = f7_base || (f7_alt && (f3 == 3'b101 || (is_reg && f3 == 3'b000)));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_o         = '0;
      dec_o.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue that decodes the WIDTH oldest entries for dispatch.
// Latency: an entry written at edge N is offered (decoded) from edge N+1.
// Backpressure: enq_ready needs WIDTH free entries, from registered count only; deq_count pops from head.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  decode_queue_if.slave              io,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int SLOT_W = $clog2(WIDTH+1);

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SLOT_W-1:0] n_enq, n_deq, n_avail;
  logic              enq_fire;

  assign io.enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
  assign enq_fire     = io.enq_ready && (|io.enq_valid);
  assign count        = count_q;

  // Slot counts: accepted enqueues, entries on offer, and the clamped number actually popped
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < WIDTH; i++) n_enq = n_enq + SLOT_W'(io.enq_valid[i]);
    n_avail = (count_q < CNT_W'(WIDTH)) ? SLOT_W'(count_q) : SLOT_W'(WIDTH);
    n_deq   = (io.deq_count > n_avail) ? n_avail : io.deq_count;
  end

  // Pointer/occupancy update; flush wins over any same-cycle enqueue or dequeue
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = head_q + PTR_W'(n_deq);
      if (enq_fire) tail_d = tail_q + PTR_W'(n_enq);
      count_d = count_q + (enq_fire ? CNT_W'(n_enq) : '0) - CNT_W'(n_deq);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage has no reset: occupancy alone decides which entries mean anything
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (io.enq_valid[i]) begin
          inst_mem[tail_q + PTR_W'(i)] <= io.enq_inst[i*32 +: 32];
          pc_mem[tail_q + PTR_W'(i)]   <= io.enq_pc[i*32 +: 32];
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    logic [PTR_W-1:0] rd_idx;
    dec_t             dec;

    assign rd_idx = head_q + PTR_W'(i);

    decode_slot u_decode_slot (
      .inst_i (inst_mem[rd_idx]),
      .dec_o  (dec)
    );

    assign io.deq_valid[i]                              = CNT_W'(i) < count_q;
    assign io.deq_pc[i*32 +: 32]                        = pc_mem[rd_idx];
    assign io.deq_fu_type[i*3 +: 3]                     = dec.fu;
    assign io.deq_reg_write[i]                          = dec.reg_write;
    assign io.deq_illegal[i]                            = dec.illegal;
    assign io.deq_imm_sel[i*4 +: 4]                     = dec.imm_sel;
    assign io.deq_opa_sel[i*2 +: 2]                     = dec.opa_sel;
    assign io.deq_opb_sel[i*2 +: 2]                     = dec.opb_sel;
    assign io.deq_alu_ctrl[i*ALU_OP_WIDTH +: ALU_OP_WIDTH] = dec.alu;
    assign io.deq_mem_ctrl[i*LSQ_OP_WIDTH +: LSQ_OP_WIDTH] = dec.mem;
    assign io.deq_bra_ctrl[i*BRA_OP_WIDTH +: BRA_OP_WIDTH] = dec.bra;
  end

  // Consumers may take only what is offered; producers fill slots contiguously from slot 0
  a_deq_count_le_valid: assert property (@(posedge clk) disable iff (!rst_n)
    io.deq_count <= n_avail);
  a_enq_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
    ((io.enq_valid + WIDTH'(1)) & io.enq_valid) == '0);
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 2: instructions enqueued, decoded and offered per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8: instruction entries; power of two, >= 2*WIDTH.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports clk and rst_n.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  discard all held entries (mispredict/exception).
REQ-007 enq_valid  in  WIDTH  per-slot valid; contiguous from slot 0.
REQ-008 enq_inst  in  WIDTH*32  raw instructions.
REQ-009 enq_pc  in  WIDTH*32  instruction PCs.
REQ-010 enq_ready  out  1  high when free entries >= WIDTH.
REQ-011 deq_valid  out  WIDTH  slot i valid when i < count.
REQ-012 deq_pc  out  WIDTH*32  PC of each offered entry.
REQ-013 deq_fu_type  out  WIDTH*3  ALU/LSQ/BRA unit code.
REQ-014 deq_reg_write, deq_illegal  out  WIDTH each  rd write enable; unsupported encoding.
REQ-015 deq_imm_sel  out  WIDTH*4; deq_opa_sel, deq_opb_sel  out  WIDTH*2 each.
REQ-016 deq_alu_ctrl, deq_mem_ctrl, deq_bra_ctrl  out  WIDTH*ALU_OP_WIDTH, WIDTH*LSQ_OP_WIDTH, WIDTH*BRA_OP_WIDTH.
REQ-017 deq_count  in  clog2(WIDTH+1)  entries consumed this cycle, from slot 0.
REQ-018 count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-019 Enqueue SHALL occur when enq_ready && |enq_valid; accepted number = popcount(enq_valid), written at tail in slot order.
REQ-020 enq_ready SHALL derive from registered count only (no combinational path from deq_count).
REQ-021 Decode SHALL be combinational from stored instruction to deq_* fields; entry enqueued in cycle N is offered no earlier than N+1.
REQ-022 Decode SHALL cover RV32I: R-type ALU, I-type ALU incl. shifts, loads, stores, branches, JAL, JALR, LUI, AUIPC; load/store/AUIPC use ALU ADD, LUI uses OUTB.
REQ-023 Any other encoding SHALL set deq_illegal=1, deq_reg_write=0, all other ctrl fields 0, fu_type 0; entry still occupies a slot in order.
REQ-024 Dequeue SHALL remove deq_count entries from head; deq_count > popcount(deq_valid) is a protocol error (assertion), RTL clamps to valid count.
REQ-025 Simultaneous enq/deq: count_next = count + n_enq - n_deq; head, tail pointers wrap modulo DEPTH.
REQ-026 Program order SHALL be preserved across pointer wrap-around.
REQ-027 flush SHALL take priority: next cycle count=0, head=tail=0; same-cycle enq and deq ignored.
REQ-028 deq_* fields of invalid slots SHALL be don't-care; consumers qualify with deq_valid.
REQ-029 Non-contiguous enq_valid is a protocol error (assertion).

Reset
REQ-030 rst_n low SHALL immediately force count=0, head=tail=0, deq_valid=0, enq_ready=1.
REQ-031 Instruction/PC storage SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries, identical to power-up.

Structure
REQ-033 Opcode constants, FU codes, ImmSel codes, ALU/LSQ/BRA op encodings and widths SHALL live in the shared defines package.
REQ-034 Single-instruction decode SHALL be sub-module decode_slot, instantiated WIDTH times on head+i entries.
REQ-035 Storage SHALL be a flat register array with head/tail pointers and occupancy counter.

Verification (WIDTH=2, DEPTH=8)
REQ-036 Enq 0x003100B3 (add) pc 0x100, 0x00500093 (addi) pc 0x104 -> next cycle deq_valid=11, both FU ALU, ALU ADD, opb_sel 10 then 01, reg_write=11.
REQ-037 Four cycles enq 2, deq_count=0 -> count=8, enq_ready=0; then deq_count=1 -> count=7, enq_ready=0; deq_count=2 -> count=5, enq_ready=1.
REQ-038 Enq 2/deq 2 every cycle for 12 cycles, PCs 0x0,0x4,... -> deq_pc sequence strictly increasing by 4 across wrap, count constant 2.
REQ-039 Enq 0xFFFFFFFF -> deq_illegal=1, reg_write=0, all ctrl 0, deq_valid=01.
REQ-040 count=6, flush with enq 2 and deq_count=2 same cycle -> next cycle count=0, deq_valid=00, enq_ready=1.
REQ-041 count=5, rst_n low between edges -> count=0, deq_valid=00 before next edge; release -> first enq offered one cycle later.
